mtsp_unpack_sequencer: RTL and testbench

Time-multiplexes one DWORD→byte saturating unpack element across the LANES channel DWORDs of a thread's colour result and assembles one packed pixel word. Sits between the MTSP thread write-back stage (4 channel DWORDs + thread ID per request) and the render-output/FIFO path (32-bit pixel per request). Uses valid/ready handshakes on both sides and keeps a saturation-event counter for the register file.

---
 rtl/mtsp_unpack_pkg.sv | 15 +
 rtl/mtsp_unpack_sequencer_if.sv | 16 +
 rtl/mtsp_saturate_u8.sv | 25 ++
 rtl/mtsp_unpack_sequencer.sv | 136 +++++++++++++
 tb/tb_mtsp_unpack_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mtsp_unpack_pkg.sv
// Shared types and bit positions for the MTSP DWORD->byte unpack sequencer.
package mtsp_unpack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Bits 31:24 of a channel DWORD carry no colour information.
  localparam int SIGN_BIT = 23;
  localparam int OVER_MSB = 22;
  localparam int OVER_LSB = 8;

endpackage

// File: rtl/mtsp_unpack_sequencer_if.sv
// Valid/ready stream carrying a data word, a thread ID and a saturation flag.
interface mtsp_unpack_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 5
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ID_W-1:0]   id;
  logic              sat;

  modport master (output valid, data, id, sat, input ready);
  modport slave  (input valid, data, id, sat, output ready);

endinterface

// File: rtl/mtsp_saturate_u8.sv
// Combinational DWORD->byte clamp: negative values go to 0, overflow to 255.
module mtsp_saturate_u8
  import mtsp_unpack_pkg::*;
(
  input  logic [SIGN_BIT:0] d,
  output logic [7:0]        q,
  output logic              clamped
);

  logic over;

  assign over    = |d[OVER_MSB:OVER_LSB];
  assign clamped = d[SIGN_BIT] | over;

  // The sign bit wins over the overflow bits.
  always_comb begin
    q = d[7:0];
    if (d[SIGN_BIT]) begin
      q = 8'h00;
    end else if (over) begin
      q = 8'hFF;
    end
  end

endmodule

// File: rtl/mtsp_unpack_sequencer.sv
// Steps one shared saturate element across the channel DWORDs of a thread
// result and presents the packed pixel on a valid/ready output stream.
module mtsp_unpack_sequencer
  import mtsp_unpack_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int ID_WIDTH  = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  mtsp_unpack_sequencer_if.slave  s,
  mtsp_unpack_sequencer_if.master m,
  output logic [CNT_WIDTH-1:0]  sat_count
);

  localparam int                IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int                DW       = SIGN_BIT + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  state_t                    state;
  state_t                    state_next;
  logic [LANES-1:0][DW-1:0]  in_data;
  logic [ID_WIDTH-1:0]       in_id;
  logic [IDX_W-1:0]          idx;
  logic [8*LANES-1:0]        result;
  logic [8*LANES-1:0]        result_next;
  logic                      sat_acc;
  logic [8*LANES-1:0]        out_data;
  logic [ID_WIDTH-1:0]       out_id;
  logic                      out_sat;
  logic [DW-1:0]             lane_d;
  logic [7:0]                lane_byte;
  logic                      lane_clamped;
  logic                      last_lane;
  logic                      s_ready;
  logic                      m_valid;
  logic                      accept;
  logic                      m_fire;

  assign lane_d    = in_data[idx];
  assign last_lane = (idx == LAST_IDX);

  mtsp_saturate_u8 u_sat (
    .d       (lane_d),
    .q       (lane_byte),
    .clamped (lane_clamped)
  );

  always_comb begin
    result_next               = result;
    result_next[8*idx +: 8]   = lane_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // OUT may hand off and accept the next request in the same cycle.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s.valid) state_next = CONV;
      end
      CONV: begin
        if (last_lane) state_next = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        s_ready = m.ready;
        if (m.ready) state_next = s.valid ? CONV : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = s.valid & s_ready;
  assign m_fire = m_valid & m.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_data  <= '0;
      in_id    <= '0;
      idx      <= '0;
      result   <= '0;
      sat_acc  <= 1'b0;
      out_data <= '0;
      out_id   <= '0;
      out_sat  <= 1'b0;
    end else if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        in_data[k] <= s.data[32*k +: DW];
      end
      in_id   <= s.id;
      idx     <= '0;
      sat_acc <= 1'b0;
    end else if (state == CONV) begin
      result  <= result_next;
      sat_acc <= sat_acc | lane_clamped;
      if (last_lane) begin
        out_data <= result_next;
        out_id   <= in_id;
        out_sat  <= sat_acc | lane_clamped;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Clear has priority over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (clr) begin
      sat_count <= '0;
    end else if (m_fire && out_sat && !(&sat_count)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

  assign s.ready = s_ready;
  assign m.valid = m_valid;
  assign m.data  = out_data;
  assign m.id    = out_id;
  assign m.sat   = out_sat;

endmodule

// File: tb/tb_mtsp_unpack_sequencer.sv
// Directed bench for mtsp_unpack_sequencer; a narrow-counter twin shadows the
// main instance so counter saturation is reachable in a short run.
module tb_mtsp_unpack_sequencer;

  localparam int LANES = 4;
  localparam int IDW   = 5;
  localparam int CW    = 16;
  localparam int CWS   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [CW-1:0]  sat_count;
  logic [CWS-1:0] sat_count_s;

  always #5 clk = ~clk;

  mtsp_unpack_sequencer_if #(.DATA_W(32*LANES), .ID_W(IDW)) s_if ();
  mtsp_unpack_sequencer_if #(.DATA_W(8*LANES),  .ID_W(IDW)) m_if ();
  mtsp_unpack_sequencer_if #(.DATA_W(32*LANES), .ID_W(IDW)) s2_if ();
  mtsp_unpack_sequencer_if #(.DATA_W(8*LANES),  .ID_W(IDW)) m2_if ();

  assign s2_if.valid = s_if.valid;
  assign s2_if.data  = s_if.data;
  assign s2_if.id    = s_if.id;
  assign s2_if.sat   = s_if.sat;
  assign m2_if.ready = m_if.ready;

  mtsp_unpack_sequencer #(.LANES(LANES), .ID_WIDTH(IDW), .CNT_WIDTH(CW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .s         (s_if),
    .m         (m_if),
    .sat_count (sat_count)
  );

  mtsp_unpack_sequencer #(.LANES(LANES), .ID_WIDTH(IDW), .CNT_WIDTH(CWS)) u_dut_small (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .s         (s2_if),
    .m         (m2_if),
    .sat_count (sat_count_s)
  );

  typedef struct {
    logic [127:0] data;
    logic [4:0]   id;
    logic [31:0]  exp_data;
    logic         exp_sat;
  } vec_t;

  vec_t vecs [6];

  int tests = 0;
  int fails = 0;
  logic [CW-1:0]  exp_cnt   = '0;
  logic [CWS-1:0] exp_cnt_s = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_transfer(input logic sat);
    if (sat) begin
      if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      if (exp_cnt_s != {CWS{1'b1}}) exp_cnt_s = exp_cnt_s + 1'b1;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_sat_count"}, 128'(sat_count), 128'(exp_cnt));
    check({tag, "_sat_count_small"}, 128'(sat_count_s), 128'(exp_cnt_s));
  endtask

  // All tasks start and end #1 after a rising edge.
  task automatic apply_stimulus(input logic [127:0] d, input logic [4:0] id);
    int w = 0;
    while (!s_if.ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("s_ready_before_accept", 128'(s_if.ready), 128'(1));
    s_if.data  = d;
    s_if.id    = id;
    s_if.valid = 1'b1;
    @(posedge clk); #1;
    s_if.valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!m_if.valid && cycles < 20) begin
      @(posedge clk); #1; cycles++;
    end
    check("m_valid_timeout", 128'(m_if.valid), 128'(1));
  endtask

  task automatic check_output(input logic [31:0] ed, input logic [4:0] eid, input logic esat);
    int c;
    wait_valid(c);
    check("latency", 128'(c), 128'(LANES));
    check("m_data", 128'(m_if.data), 128'(ed));
    check("m_id", 128'(m_if.id), 128'(eid));
    check("m_sat", 128'(m_if.sat), 128'(esat));
    @(posedge clk); #1;
    model_transfer(esat);
    check("m_valid_after_xfer", 128'(m_if.valid), 128'(0));
    check_counts("xfer");
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{{32'h0000_0080, 32'h0000_00FF, 32'h0080_0010, 32'h0000_0100}, 5'd1,  32'h80FF_00FF, 1'b1};
    vecs[1] = '{{32'hFF00_0078, 32'hFF00_0056, 32'hFF00_0034, 32'hFF00_0012}, 5'd2,  32'h7856_3412, 1'b0};
    vecs[2] = '{128'h0,                                                        5'd3,  32'h0000_0000, 1'b0};
    vecs[3] = '{{32'h0000_7F00, 32'h00FF_FFFF, 32'h0040_0000, 32'h0000_00FF}, 5'd4,  32'hFF00_FFFF, 1'b1};
    vecs[4] = '{{32'h0000_0100, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001}, 5'd5,  32'hFF03_0201, 1'b1};
    vecs[5] = '{{32'h0000_00EF, 32'h0080_0000, 32'h0000_00CD, 32'h0000_00AB}, 5'd31, 32'hEF00_CDAB, 1'b1};

    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.id    = '0;
    s_if.sat   = 1'b0;
    m_if.ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_s_ready", 128'(s_if.ready), 128'(1));
    check("reset_m_valid", 128'(m_if.valid), 128'(0));
    check("reset_m_data", 128'(m_if.data), 128'(0));
    check("reset_m_id", 128'(m_if.id), 128'(0));
    check("reset_m_sat", 128'(m_if.sat), 128'(0));
    check_counts("reset");

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].data, vecs[i].id);
      check_output(vecs[i].exp_data, vecs[i].id, vecs[i].exp_sat);
    end

    // Back-to-back: S_VALID held, one pixel every LANES+1 cycles, IDs in order.
    begin
      logic [127:0] bd [3];
      logic [31:0]  bexp [3];
      logic         bsat [3];
      int n = 0, got = 0, cyc = 0, last = 0;
      logic acc, xfer, xsat;
      bd[0] = vecs[0].data; bexp[0] = vecs[0].exp_data; bsat[0] = vecs[0].exp_sat;
      bd[1] = vecs[3].data; bexp[1] = vecs[3].exp_data; bsat[1] = vecs[3].exp_sat;
      bd[2] = vecs[1].data; bexp[2] = vecs[1].exp_data; bsat[2] = vecs[1].exp_sat;
      s_if.data  = bd[0];
      s_if.id    = 5'd10;
      s_if.valid = 1'b1;
      while (got < 3 && cyc < 60) begin
        acc  = s_if.valid & s_if.ready;
        xfer = m_if.valid;
        xsat = 1'b0;
        if (xfer) begin
          check("b2b_data", 128'(m_if.data), 128'(bexp[got]));
          check("b2b_id", 128'(m_if.id), 128'(5'd10 + 5'(got)));
          check("b2b_sat", 128'(m_if.sat), 128'(bsat[got]));
          check("b2b_s_ready_in_out", 128'(s_if.ready), 128'(1));
          if (got > 0) check("b2b_spacing", 128'(cyc - last), 128'(LANES + 1));
          last = cyc;
          xsat = bsat[got];
          got++;
        end
        @(posedge clk); #1; cyc++;
        if (xfer) begin
          model_transfer(xsat);
          check_counts("b2b");
        end
        if (acc) begin
          n++;
          if (n < 3) begin
            s_if.data = bd[n];
            s_if.id   = 5'd10 + 5'(n);
          end else begin
            s_if.valid = 1'b0;
          end
        end
      end
      s_if.valid = 1'b0;
      check("b2b_done", 128'(got), 128'(3));
      check("b2b_idle_after", 128'(m_if.valid), 128'(0));
    end

    // Back-pressure: outputs frozen and S_READY low while M_READY is low.
    begin
      int c;
      m_if.ready = 1'b0;
      apply_stimulus(vecs[5].data, 5'd7);
      wait_valid(c);
      for (int k = 0; k < 10; k++) begin
        check("bp_m_valid", 128'(m_if.valid), 128'(1));
        check("bp_m_data", 128'(m_if.data), 128'(vecs[5].exp_data));
        check("bp_m_id", 128'(m_if.id), 128'(5'd7));
        check("bp_s_ready", 128'(s_if.ready), 128'(0));
        @(posedge clk); #1;
      end
      check_counts("bp_hold");
      m_if.ready = 1'b1;
      #1;
      check("bp_s_ready_release", 128'(s_if.ready), 128'(1));
      @(posedge clk); #1;
      model_transfer(1'b1);
      check("bp_single_xfer", 128'(m_if.valid), 128'(0));
      check_counts("bp_release");
    end

    // Enough clamped pixels to pin the narrow counter at all-ones.
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(vecs[4].data, 5'(20 + k));
      check_output(vecs[4].exp_data, 5'(20 + k), 1'b1);
    end
    check("small_counter_pinned", 128'(sat_count_s), 128'({CWS{1'b1}}));

    // CLR coincident with a clamped transfer wins.
    begin
      int c;
      apply_stimulus(vecs[0].data, 5'd8);
      wait_valid(c);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      exp_cnt   = '0;
      exp_cnt_s = '0;
      check_counts("clr_coincident");
    end
    apply_stimulus(vecs[1].data, vecs[1].id);
    check_output(vecs[1].exp_data, vecs[1].id, 1'b0);
    apply_stimulus(vecs[3].data, vecs[3].id);
    check_output(vecs[3].exp_data, vecs[3].id, 1'b1);

    // Reset while the third channel is being converted drops the pixel.
    begin
      int seen = 0;
      apply_stimulus(vecs[0].data, 5'd9);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_mid_m_valid", 128'(m_if.valid), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      exp_cnt   = '0;
      exp_cnt_s = '0;
      check("rst_mid_s_ready", 128'(s_if.ready), 128'(1));
      check_counts("rst_mid");
      for (int k = 0; k < 10; k++) begin
        if (m_if.valid) seen++;
        @(posedge clk); #1;
      end
      check("rst_mid_no_output", 128'(seen), 128'(0));
    end
    apply_stimulus(vecs[5].data, vecs[5].id);
    check_output(vecs[5].exp_data, vecs[5].id, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
